// File: rtl/mac_seq_ctrl.sv
// Tap sequencer for the shared MAC datapath: clear, address sweep, pipeline drain, rescale.
// Define MAC_SEQ_CTRL_SAT_EN to saturate the rescaled result instead of wrapping it.
module mac_seq_ctrl #(
    parameter int unsigned N       = 25,
    parameter int unsigned TAPS    = 5,
    parameter int unsigned ADDR_W  = 3,
    parameter int unsigned MUL_LAT = 1,
    parameter int unsigned SHIFT   = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic [ADDR_W-1:0] tap_addr,
    output logic              mac_clr,
    output logic              mac_en,
    input  logic [2*N-1:0]    acc_in,
    output logic [N-1:0]      y_out,
    output logic              done,
    output logic              overrun,
    output logic              sat
);

    typedef enum logic [2:0] {StIdle, StClear, StRun, StDrain, StOut} state_e;

    localparam int unsigned CntW = 8;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              go_q, go_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] tap_q, tap_d;
    logic              clr_q, clr_d;
    logic [MUL_LAT:0]  pipe_q, pipe_d;
    logic [N-1:0]      y_q, y_d;
    logic              done_q, done_d;
    logic              ovr_q, ovr_d;
    logic              sat_q, sat_d;

    logic              accept;
    logic [N-1:0]      y_new;
    logic              sat_new;

`ifdef MAC_SEQ_CTRL_SAT_EN
    logic [N-SHIFT:0]  upper;
    logic              unused_acc;

    assign upper      = acc_in[2*N-1:SHIFT+N-1];
    assign unused_acc = ^acc_in[SHIFT-1:0];

    always_comb begin
        y_new   = acc_in[SHIFT+N-1:SHIFT];
        sat_new = 1'b0;
        if (!((&upper) || (~|upper))) begin
            y_new   = acc_in[2*N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
            sat_new = 1'b1;
        end
    end
`else
    logic              unused_acc;

    assign unused_acc = ^{acc_in[2*N-1:SHIFT+N], acc_in[SHIFT-1:0]};
    assign y_new      = acc_in[SHIFT+N-1:SHIFT];
    assign sat_new    = 1'b0;
`endif

    // busy_q already covers the accept cycle, the pending cycle and the done cycle.
    assign accept = start && !busy_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        go_d    = go_q;
        unique case (state_q)
            StIdle: begin
                if (go_q) begin
                    state_d = StClear;
                    go_d    = 1'b0;
                end else if (accept) begin
                    go_d = 1'b1;
                end
            end
            StClear: begin
                state_d = StRun;
                cnt_d   = '0;
            end
            StRun: begin
                if (cnt_q == CntW'(TAPS - 1)) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDrain: begin
                if (cnt_q == CntW'(MUL_LAT)) begin
                    state_d = StOut;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StOut: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
            default: state_d = StIdle;
        endcase

        busy_d = accept || go_q || (state_q != StIdle);
        ovr_d  = start && busy_q;
        clr_d  = (state_q == StClear);
        tap_d  = tap_q;
        if (state_q == StClear) begin
            tap_d = '0;
        end else if (state_q == StRun) begin
            tap_d = cnt_q[ADDR_W-1:0];
        end

        // Stage 0 is the issue flag aligned with tap_addr; the last stage is mac_en.
        pipe_d[0] = (state_q == StRun);
        for (int k = 1; k <= int'(MUL_LAT); k++) begin
            pipe_d[k] = pipe_q[k-1];
        end

        done_d = (state_q == StOut);
        y_d    = done_d ? y_new : y_q;
        sat_d  = done_d ? sat_new : sat_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            go_q    <= 1'b0;
            busy_q  <= 1'b0;
            tap_q   <= '0;
            clr_q   <= 1'b0;
            pipe_q  <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            go_q    <= go_d;
            busy_q  <= busy_d;
            tap_q   <= tap_d;
            clr_q   <= clr_d;
            pipe_q  <= pipe_d;
            y_q     <= y_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            sat_q   <= sat_d;
        end
    end

    assign busy     = busy_q;
    assign tap_addr = tap_q;
    assign mac_clr  = clr_q;
    assign mac_en   = pipe_q[MUL_LAT];
    assign y_out    = y_q;
    assign done     = done_q;
    assign overrun  = ovr_q;
    assign sat      = sat_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Scoreboard bench for mac_seq_ctrl: default instance plus a TAPS=1, MUL_LAT=3 instance.
module tb_mac_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start1 = 1'b0;
    logic [49:0] acc0 = '0;
    logic [49:0] acc1 = '0;

    logic        busy0, clr0, en0, done0, ovr0, sat0;
    logic [2:0]  tap0;
    logic [24:0] y0;
    logic        busy1, clr1, en1, done1, ovr1, sat1;
    logic [2:0]  tap1;
    logic [24:0] y1;

    mac_seq_ctrl dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy0), .tap_addr(tap0),
        .mac_clr(clr0), .mac_en(en0), .acc_in(acc0), .y_out(y0), .done(done0),
        .overrun(ovr0), .sat(sat0)
    );

    mac_seq_ctrl #(.TAPS(1), .MUL_LAT(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .tap_addr(tap1),
        .mac_clr(clr1), .mac_en(en1), .acc_in(acc1), .y_out(y1), .done(done1),
        .overrun(ovr1), .sat(sat1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [24:0] y;
        logic        s;
        int          at;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // Monitor: tap/mac_en alignment, pulse counts and result checks at each done.
    int         en_cnt = 0;
    int         clr_cnt = 0;
    int         ovr_cnt = 0;
    logic [2:0] prev_tap = '0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_cnt   = 0;
            clr_cnt  = 0;
            prev_tap = '0;
        end else begin
            if (ovr0) ovr_cnt++;
            if (clr0) clr_cnt++;
            if (en0) begin
                chk("tap_seq", 64'(prev_tap), 64'(en_cnt));
                en_cnt++;
            end
            if (done0) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 64'(1), 64'(0));
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("y_out", 64'(y0), 64'(e.y));
                    chk("sat", 64'(sat0), 64'(e.s));
                    chk("done_cycle", 64'(cyc), 64'(e.at));
                    chk("mac_en_cycles", 64'(en_cnt), 64'(5));
                    chk("mac_clr_cycles", 64'(clr_cnt), 64'(1));
                end
                en_cnt  = 0;
                clr_cnt = 0;
            end
            prev_tap = tap0;
        end
    end

    // Called on a falling edge; done lands 10 rising edges after the sampling edge.
    task automatic issue(input logic [49:0] a, input logic [24:0] y, input logic s);
        exp_t e;
        acc0 = a;
        start = 1'b1;
        e.y = y;
        e.s = s;
        e.at = cyc + 11;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done0) seen = 1'b1;
        end
        if (!seen) chk("done_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int c0;
        int en1_cnt;
        int en1_at;
        int done1_at;
        int clr1_cnt;
        int ovr1_cnt;
        logic [24:0] y1v;
        bit found;

        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy0), 64'(0));
        chk("rst_tap", 64'(tap0), 64'(0));
        chk("rst_clr", 64'(clr0), 64'(0));
        chk("rst_en", 64'(en0), 64'(0));
        chk("rst_y", 64'(y0), 64'(0));
        chk("rst_done", 64'(done0), 64'(0));
        chk("rst_ovr", 64'(ovr0), 64'(0));
        chk("rst_sat", 64'(sat0), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        issue(50'h0_0000_000A_0000, 25'h0000001, 1'b0);
        wait_done();
        @(negedge clk);
        chk("done_one_cycle", 64'(done0), 64'(0));
        chk("y_held", 64'(y0), 64'(1));
        chk("busy_after_done", 64'(busy0), 64'(0));

        issue(50'h3_FFFF_FFF8_0000, 25'h1FFFFFF, 1'b0);
        wait_done();
        @(negedge clk);
        issue(50'h3_FFFF_FFD8_0000, 25'h1FFFFFB, 1'b0);
        wait_done();
        @(negedge clk);
`ifdef MAC_SEQ_CTRL_SAT_EN
        issue(50'h0_8000_0000_0000, 25'h0FFFFFF, 1'b1);
        wait_done();
        @(negedge clk);
        issue(50'h2_0000_0000_0000, 25'h1000000, 1'b1);
`else
        issue(50'h0_8000_0000_0000, 25'h0000000, 1'b0);
        wait_done();
        @(negedge clk);
        issue(50'h2_0000_0000_0000, 25'h0000000, 1'b0);
`endif
        wait_done();
        @(negedge clk);

        // Overrun during RUN and coincident with done; start the cycle after done is taken.
        base = ovr_cnt;
        issue(50'h0_0000_0050_0000, 25'h000000A, 1'b0);
        repeat (4) @(negedge clk);
        chk("busy_in_run", 64'(busy0), 64'(1));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        start = 1'b1;
        @(negedge clk);
        begin
            exp_t e;
            acc0 = 50'h0_0000_0018_0000;
            e.y = 25'h0000003;
            e.s = 1'b0;
            e.at = cyc + 11;
            q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        wait_done();
        chk("overrun_count", 64'(ovr_cnt - base), 64'(2));
        @(negedge clk);

        // Reset while tap_addr=2: everything clears at once and no done follows.
        acc0 = 50'h0_0000_000A_0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (tap0 == 3'd2) found = 1'b1;
        end
        chk("reach_tap2", 64'(found), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("arst_y", 64'(y0), 64'(0));
        chk("arst_busy", 64'(busy0), 64'(0));
        chk("arst_tap", 64'(tap0), 64'(0));
        chk("arst_en", 64'(en0), 64'(0));
        chk("arst_done", 64'(done0), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        issue(50'h0_0000_0018_0000, 25'h0000003, 1'b0);
        wait_done();
        @(negedge clk);

        // TAPS=1, MUL_LAT=3 instance.
        acc1 = 50'h0_0000_0028_0000;
        start1 = 1'b1;
        c0 = cyc;
        en1_cnt = 0;
        en1_at = -1;
        done1_at = -1;
        clr1_cnt = 0;
        ovr1_cnt = 0;
        y1v = '0;
        @(negedge clk);
        start1 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (en1) begin
                en1_cnt++;
                en1_at = cyc;
            end
            if (clr1) clr1_cnt++;
            if (ovr1) ovr1_cnt++;
            if (done1) begin
                done1_at = cyc;
                y1v = y1;
            end
        end
        chk("l3_en_cycles", 64'(en1_cnt), 64'(1));
        chk("l3_en_at", 64'(en1_at), 64'(c0 + 7));
        chk("l3_done_at", 64'(done1_at), 64'(c0 + 9));
        chk("l3_y", 64'(y1v), 64'(5));
        chk("l3_clr", 64'(clr1_cnt), 64'(1));
        chk("l3_ovr", 64'(ovr1_cnt), 64'(0));
        chk("l3_sat", 64'(sat1), 64'(0));
        chk("l3_tap", 64'(tap1), 64'(0));
        chk("l3_busy", 64'(busy1), 64'(0));

        chk("sb_empty", 64'(q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
